// File: rtl/ro_puf_sequencer_if.sv
// ro_puf_sequencer_if: host request/response and RO PUF core handshake bundle
interface ro_puf_sequencer_if #(parameter int RESP_W = 16);
  logic START;
  logic [5:0] SEED;
  logic PUF_EN;
  logic [2:0] PUF_CHAL_0;
  logic [2:0] PUF_CHAL_1;
  logic PUF_RESPONSE;
  logic PUF_DONE;
  logic PUF_BUSY;
  logic [RESP_W-1:0] RESPONSE;
  logic DONE;
  logic BUSY;
  logic ERR;
  modport slave (
    input START, SEED, PUF_RESPONSE, PUF_DONE, PUF_BUSY,
    output PUF_EN, PUF_CHAL_0, PUF_CHAL_1, RESPONSE, DONE, BUSY, ERR
  );
  modport master (
    output START, SEED, PUF_RESPONSE, PUF_DONE, PUF_BUSY,
    input PUF_EN, PUF_CHAL_0, PUF_CHAL_1, RESPONSE, DONE, BUSY, ERR
  );
endinterface

// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: LFSR-challenged RO PUF evaluation sequencer with watchdog (RO_SEQ_MAJORITY_VOTE_EN adds 3-vote majority per bit)
module ro_puf_sequencer #(
  parameter int RESP_W = 16,
  parameter int TIMEOUT_CYC = 200000,
  parameter int GAP_CYC = 4
) (
  input logic CLK,
  input logic RST_N,
  ro_puf_sequencer_if.slave bus
);
  localparam int IW = RESP_W > 1 ? $clog2(RESP_W) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [WW-1:0] GAP_LAST = WW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(RESP_W - 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_CAPTURE, S_GAP, S_FINISH, S_ERROR} state_t;
  state_t state_q, state_d;
  logic [1:0] rst_sync_q;
  logic [5:0] lfsr_q, lfsr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic err_q, err_d;
  logic rst_n_i, last_vote, bit_val, timeout, active;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n_i = rst_sync_q[1];
`ifdef RO_SEQ_MAJORITY_VOTE_EN
  logic [1:0] vcnt_q, vcnt_d;
  logic [1:0] votes_q, votes_d;
  assign last_vote = vcnt_q == 2'd2;
  assign bit_val = (votes_q[0] & votes_q[1]) | (votes_q[0] & bus.PUF_RESPONSE) | (votes_q[1] & bus.PUF_RESPONSE);
  always_ff @(posedge CLK or negedge rst_n_i)
    if (!rst_n_i) begin
      vcnt_q <= 2'd0;
      votes_q <= 2'b00;
    end else begin
      vcnt_q <= vcnt_d;
      votes_q <= votes_d;
    end
  always_comb begin
    vcnt_d = vcnt_q;
    votes_d = votes_q;
    if (state_q == S_IDLE && bus.START) vcnt_d = 2'd0;
    else if (state_q == S_CAPTURE) begin
      vcnt_d = last_vote ? 2'd0 : vcnt_q + 2'd1;
      if (!last_vote) votes_d[vcnt_q[0]] = bus.PUF_RESPONSE;
    end
  end
`else
  assign last_vote = 1'b1;
  assign bit_val = bus.PUF_RESPONSE;
`endif
  assign timeout = wdog_q == TO_LAST;
  assign active = state_q inside {S_LOAD, S_ARM, S_WAIT, S_CAPTURE, S_GAP};
  assign bus.PUF_EN = state_q == S_ARM || state_q == S_WAIT;
  assign bus.PUF_CHAL_0 = active ? lfsr_q[2:0] : 3'd0;
  assign bus.PUF_CHAL_1 = active ? lfsr_q[5:3] : 3'd0;
  assign bus.RESPONSE = resp_q;
  assign bus.DONE = state_q == S_FINISH;
  assign bus.BUSY = active;
  assign bus.ERR = err_q;
  always_ff @(posedge CLK or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      lfsr_q <= 6'h01;
      idx_q <= '0;
      wdog_q <= '0;
      resp_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      idx_q <= idx_d;
      wdog_q <= wdog_d;
      resp_q <= resp_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    idx_d = idx_q;
    resp_d = resp_q;
    err_d = err_q;
    wdog_d = timeout ? wdog_q : wdog_q + WW'(1);
    case (state_q)
      S_IDLE: if (bus.START) begin
        state_d = S_LOAD;
        lfsr_d = bus.SEED == 6'h00 ? 6'h01 : bus.SEED;
        idx_d = '0;
        resp_d = '0;
        err_d = 1'b0;
      end
      S_LOAD: begin
        state_d = S_ARM;
        wdog_d = '0;
      end
      S_ARM: begin
        state_d = timeout ? S_ERROR : bus.PUF_BUSY ? S_WAIT : S_ARM;
        err_d = timeout;
      end
      S_WAIT: begin
        state_d = timeout ? S_ERROR : bus.PUF_DONE ? S_CAPTURE : S_WAIT;
        err_d = timeout;
      end
      S_CAPTURE: begin
        wdog_d = '0;
        state_d = S_GAP;
        if (last_vote) begin
          resp_d[idx_q] = bit_val;
          lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
          state_d = idx_q == IDX_LAST ? S_FINISH : S_GAP;
          idx_d = idx_q == IDX_LAST ? idx_q : idx_q + IW'(1);
        end
      end
      S_GAP: begin
        state_d = timeout ? S_ERROR : (!bus.PUF_BUSY && !bus.PUF_DONE && wdog_q >= GAP_LAST) ? S_LOAD : S_GAP;
        err_d = timeout;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb_ro_puf_sequencer: directed table-driven bench with a behavioural RO PUF core model
module tb_ro_puf_sequencer;
  localparam int RESP_W = 16;
  localparam int TIMEOUT_CYC = 500;
  localparam int GAP_CYC = 4;
`ifdef RO_SEQ_MAJORITY_VOTE_EN
  localparam int VOTES = 3;
`else
  localparam int VOTES = 1;
`endif
  localparam int RUN_LIMIT = RESP_W * VOTES * 130;
  typedef struct {
    logic [5:0] seed;
    logic [15:0] exp;
  } vec_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int errors = 0;
  logic busy_m = 1'b0;
  logic done_m = 1'b0;
  logic en_prev = 1'b0;
  int cnt_m = 0;
  int evals = 0;
  int base = 0;
  int hang_at = -1;
  int rel;
  logic maj_mode = 1'b0;
  logic [5:0] pat = 6'b010101;
  vec_t vecs[3];
  always #5 CLK = ~CLK;
  ro_puf_sequencer_if #(.RESP_W(RESP_W)) bus();
  ro_puf_sequencer #(.RESP_W(RESP_W), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );
  assign rel = evals - base;
  assign bus.PUF_BUSY = busy_m;
  assign bus.PUF_DONE = done_m;
  assign bus.PUF_RESPONSE = (maj_mode && rel >= 1 && rel <= 6) ? pat[3'(rel - 1)] : (bus.PUF_CHAL_0 > bus.PUF_CHAL_1);
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      busy_m <= 1'b0;
      done_m <= 1'b0;
      en_prev <= 1'b0;
      cnt_m <= 0;
    end else begin
      en_prev <= bus.PUF_EN;
      if (bus.PUF_EN && !en_prev) evals <= evals + 1;
      if (!bus.PUF_EN) begin
        busy_m <= 1'b0;
        done_m <= 1'b0;
      end else if (!busy_m && !done_m) begin
        busy_m <= 1'b1;
        cnt_m <= 0;
      end else if (busy_m && cnt_m == 98 && evals != hang_at) begin
        busy_m <= 1'b0;
        done_m <= 1'b1;
      end else if (busy_m) cnt_m <= cnt_m + 1;
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic start_req(input logic [5:0] seed);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.SEED = seed;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < RUN_LIMIT; c++) begin
      if (bus.DONE) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask
  task automatic wait_evals(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < RUN_LIMIT; c++) begin
      if (evals - base >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask
  initial begin
    bit ok;
    bit saw_done;
    int k;
    vecs[0] = '{seed: 6'h01, exp: 16'h71C7};
    vecs[1] = '{seed: 6'h00, exp: 16'h71C7};
    vecs[2] = '{seed: 6'h3F, exp: 16'h0000};
    vecs[2] = '{seed: 6'h2A, exp: 16'h703A};
    bus.START = 1'b1;
    bus.SEED = 6'h2A;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_en", bus.PUF_EN, 0);
    chk("rst_chal", {bus.PUF_CHAL_1, bus.PUF_CHAL_0}, 0);
    chk("rst_resp", bus.RESPONSE, 0);
    chk("rst_flags", {bus.DONE, bus.BUSY, bus.ERR}, 0);
    bus.START = 1'b0;
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_busy", bus.BUSY, 0);
    base = evals;
    start_req(6'h2A);
    chk("load_chal0", bus.PUF_CHAL_0, 3'b010);
    chk("load_chal1", bus.PUF_CHAL_1, 3'b101);
    chk("load_en", bus.PUF_EN, 0);
    chk("load_busy", bus.BUSY, 1);
    @(negedge CLK);
    chk("arm_en", bus.PUF_EN, 1);
    wait_evals(1, ok);
    chk("first_eval", ok, 1);
    repeat (5) @(negedge CLK);
    bus.START = 1'b1;
    bus.SEED = 6'h01;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("ign_chal", {bus.PUF_CHAL_1, bus.PUF_CHAL_0}, 6'b101010);
    chk("ign_evals", evals - base, 1);
    chk("ign_en", bus.PUF_EN, 1);
    wait_done(ok);
    chk("ign_done", ok, 1);
    chk("ign_resp", bus.RESPONSE, 16'h703A);
    chk("ign_total", evals - base, RESP_W * VOTES);
    for (int i = 0; i < 3; i++) begin
      base = evals;
      start_req(vecs[i].seed);
      wait_done(ok);
      chk($sformatf("v%0d_done", i), ok, 1);
      chk($sformatf("v%0d_resp", i), bus.RESPONSE, vecs[i].exp);
      chk($sformatf("v%0d_busy", i), bus.BUSY, 0);
      chk($sformatf("v%0d_err", i), bus.ERR, 0);
      chk($sformatf("v%0d_evals", i), evals - base, RESP_W * VOTES);
      @(negedge CLK);
      chk($sformatf("v%0d_pulse", i), bus.DONE, 0);
      chk($sformatf("v%0d_hold", i), bus.RESPONSE, vecs[i].exp);
    end
    base = evals;
    hang_at = evals + 2 * VOTES + 1;
    start_req(6'h01);
    wait_evals(2 * VOTES + 1, ok);
    chk("to_reach", ok, 1);
    saw_done = 1'b0;
    k = 0;
    while (!bus.ERR && k < 1000) begin
      @(negedge CLK);
      k++;
      if (bus.DONE) saw_done = 1'b1;
    end
    chk("to_err", bus.ERR, 1);
    chk("to_cycles", k, 499);
    chk("to_en", bus.PUF_EN, 0);
    chk("to_busy", bus.BUSY, 0);
    chk("to_nodone", saw_done, 0);
    chk("to_resp", bus.RESPONSE, 16'h0003);
    hang_at = -1;
    repeat (3) @(negedge CLK);
    chk("to_sticky", bus.ERR, 1);
    base = evals;
    start_req(6'h01);
    chk("rs_errclr", bus.ERR, 0);
    wait_done(ok);
    chk("rs_done", ok, 1);
    chk("rs_resp", bus.RESPONSE, 16'h71C7);
    base = evals;
    start_req(6'h01);
    wait_evals(2 * VOTES + 1, ok);
    chk("mr_reach", ok, 1);
    chk("mr_pre", bus.RESPONSE, 16'h0003);
    #2 RST_N = 1'b0;
    #1;
    chk("mr_en", bus.PUF_EN, 0);
    chk("mr_busy", bus.BUSY, 0);
    chk("mr_resp", bus.RESPONSE, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
`ifdef RO_SEQ_MAJORITY_VOTE_EN
    maj_mode = 1'b1;
    base = evals;
    start_req(6'h01);
    wait_done(ok);
    chk("mv_done", ok, 1);
    chk("mv_resp", bus.RESPONSE, 16'h71C5);
    chk("mv_evals", evals - base, 48);
    maj_mode = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
